recwind_in_arb: RTL and testbench

Packet-atomic, two-input round-robin arbiter that merges two NetFPGA user-datapath streams into the single input of the receive-window modifier stage. Each input is buffered in a small fallthrough FIFO. Once a port is granted, its whole packet (module control headers, data words, EOP word) is forwarded contiguously before the other port is considered. It is inserted in the user datapath directly upstream of the receive-window modifier and has no register interface.

---
 rtl/recwind_in_arb_if.sv | 32 +++
 rtl/recwind_in_arb.sv | 137 +++++++++++++
 tb/tb_recwind_in_arb.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/recwind_in_arb_if.sv
// Bus bundle for recwind_in_arb: two NetFPGA-style input streams and one output stream.
interface recwind_in_arb_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] in0_data;
  logic [CTRL_WIDTH-1:0] in0_ctrl;
  logic                  in0_wr;
  logic                  in0_rdy;
  logic [DATA_WIDTH-1:0] in1_data;
  logic [CTRL_WIDTH-1:0] in1_ctrl;
  logic                  in1_wr;
  logic                  in1_rdy;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CTRL_WIDTH-1:0] out_ctrl;
  logic                  out_wr;
  logic                  out_rdy;

  // Traffic source / sink side
  modport master (
    output in0_data, in0_ctrl, in0_wr, input in0_rdy,
    output in1_data, in1_ctrl, in1_wr, input in1_rdy,
    input  out_data, out_ctrl, out_wr, output out_rdy
  );

  // Arbiter side
  modport slave (
    input  in0_data, in0_ctrl, in0_wr, output in0_rdy,
    input  in1_data, in1_ctrl, in1_wr, output in1_rdy,
    output out_data, out_ctrl, out_wr, input out_rdy
  );
endinterface

// File: rtl/recwind_in_arb.sv
// Packet-atomic two-input round-robin arbiter feeding the receive-window modifier.
// Each input has a small fallthrough FIFO; a granted port forwards its whole packet.
module recwind_in_arb #(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int FIFO_DEPTH_BITS = 2
) (
  input logic             clk,
  input logic             reset,
  recwind_in_arb_if.slave bus
);

  localparam int DEPTH  = 1 << FIFO_DEPTH_BITS;
  localparam int WORD_W = DATA_WIDTH + CTRL_WIDTH;
  localparam int CNT_W  = FIFO_DEPTH_BITS + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_NF   = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  logic [WORD_W-1:0]          in_word [2];
  logic [1:0]                 in_wr;
  logic [WORD_W-1:0]          mem     [2][DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr  [2];
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr  [2];
  logic [CNT_W-1:0]           count   [2];
  logic [WORD_W-1:0]          head    [2];
  logic [1:0]                 empty;
  logic [1:0]                 full;
  logic [1:0]                 nearly_full;
  logic [1:0]                 wr_en;
  logic [1:0]                 rd_en;

  state_t            state, state_nxt;
  logic              grant, grant_nxt;
  logic              last, last_nxt;
  logic              xfer;
  logic [WORD_W-1:0] out_word;
  logic [CTRL_WIDTH-1:0] head_ctrl;

  assign in_word[0] = {bus.in0_ctrl, bus.in0_data};
  assign in_word[1] = {bus.in1_ctrl, bus.in1_data};
  assign in_wr      = {bus.in1_wr, bus.in0_wr};

  assign bus.in0_rdy = !nearly_full[0];
  assign bus.in1_rdy = !nearly_full[1];
  assign {bus.out_ctrl, bus.out_data} = out_word;
  assign bus.out_wr  = xfer;

  // FIFO status flags and head words (fallthrough: head is visible once written)
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      empty[p]       = (count[p] == '0);
      full[p]        = (count[p] == CNT_FULL);
      nearly_full[p] = (count[p] >= CNT_NF);
      wr_en[p]       = in_wr[p] && !full[p];
      head[p]        = mem[p][rd_ptr[p]];
    end
  end

  // FIFO storage, written independently of arbitration
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < 2; p++) begin
      if (wr_en[p]) begin
        mem[p][wr_ptr[p]] <= in_word[p];
      end
    end
  end

  // FIFO pointers and occupancy; reset flushes both FIFOs
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < 2; p++) begin
      if (!reset) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
        count[p]  <= '0;
      end else begin
        if (wr_en[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
        if (rd_en[p]) rd_ptr[p] <= rd_ptr[p] + 1'b1;
        case ({wr_en[p], rd_en[p]})
          2'b10:   count[p] <= count[p] + 1'b1;
          2'b01:   count[p] <= count[p] - 1'b1;
          default: count[p] <= count[p];
        endcase
      end
    end
  end

  // Arbitration state register; last=1 out of reset gives port 0 first priority
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      grant <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
    end
  end

  // Next-state: grant in IDLE, leave HDR on first data word, leave BODY on EOP
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (!empty[0] || !empty[1]) begin
          state_nxt = HDR;
          if (!empty[0] && !empty[1]) grant_nxt = !last;
          else                        grant_nxt = empty[0];
        end
      end
      HDR: begin
        if (xfer && (head_ctrl == '0)) state_nxt = BODY;
      end
      BODY: begin
        if (xfer && (head_ctrl != '0)) begin
          state_nxt = IDLE;
          last_nxt  = grant;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: forward the granted FIFO head whenever it exists and downstream is ready
  always_comb begin
    out_word  = grant ? head[1] : head[0];
    head_ctrl = out_word[WORD_W-1 -: CTRL_WIDTH];
    xfer      = (state != IDLE) && !empty[grant] && bus.out_rdy;
    rd_en     = '0;
    if (xfer) rd_en[grant] = 1'b1;
  end

endmodule

// File: tb/tb_recwind_in_arb.sv
// Directed self-checking bench for recwind_in_arb.
module tb_recwind_in_arb;
  localparam int DW = 64;
  localparam int CW = 8;

  typedef struct {
    logic [7:0]  c;
    logic [63:0] d;
    int unsigned cy;
  } cap_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  recwind_in_arb_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus ();

  recwind_in_arb #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .FIFO_DEPTH_BITS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cap_t cap[$];
  // Record every word accepted downstream, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.out_wr === 1'b1) cap.push_back('{c: bus.out_ctrl, d: bus.out_data, cy: cyc});
  end

  int n_assert = 0;
  int n_fail = 0;
  logic [71:0] src0 [40];
  logic [71:0] src1 [40];
  int unsigned fed [2];
  int unsigned k;
  int unsigned b;
  int t;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input int idx, input logic [71:0] exp, input int unsigned exp_cy);
    if (idx < cap.size()) begin
      chk({tag, "_word"}, {cap[idx].c, cap[idx].d}, exp);
      chk({tag, "_cycle"}, 72'(cap[idx].cy), 72'(exp_cy));
    end else begin
      chk({tag, "_missing"}, 72'(cap.size()), 72'(idx + 1));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_port(input int port, input logic v, input logic [71:0] w);
    if (port == 0) begin
      bus.in0_wr = v; bus.in0_ctrl = w[71:64]; bus.in0_data = w[63:0];
    end else begin
      bus.in1_wr = v; bus.in1_ctrl = w[71:64]; bus.in1_data = w[63:0];
    end
  endtask

  task automatic feed(input int port, input int first, input int n);
    int tw;
    logic rdy;
    for (int i = 0; i < n; i++) begin
      tw = 0;
      wr_port(port, 1'b0, '0);
      rdy = (port == 0) ? bus.in0_rdy : bus.in1_rdy;
      while (rdy !== 1'b1 && tw < 200) begin
        tick();
        tw++;
        rdy = (port == 0) ? bus.in0_rdy : bus.in1_rdy;
      end
      if (tw >= 200) begin
        chk($sformatf("feed%0d_rdy_timeout", port), 72'(rdy), 72'(1));
        return;
      end
      wr_port(port, 1'b1, (port == 0) ? src0[first + i] : src1[first + i]);
      tick();
      fed[port]++;
    end
    wr_port(port, 1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Stimulus tables
    for (int p = 0; p < 3; p++) begin
      src0[p*4+0] = {8'hFF, 56'd0, 8'(8'hA0 + p)};
      src0[p*4+1] = {8'h00, 64'(32'h1000 + p*16 + 1)};
      src0[p*4+2] = {8'h00, 64'(32'h1000 + p*16 + 2)};
      src0[p*4+3] = {8'h01, 64'(32'h1000 + p*16 + 3)};
      src1[p*4+0] = {8'hFF, 56'd0, 8'(8'hB0 + p)};
      src1[p*4+1] = {8'h00, 64'(32'h2000 + p*16 + 1)};
      src1[p*4+2] = {8'h00, 64'(32'h2000 + p*16 + 2)};
      src1[p*4+3] = {8'h01, 64'(32'h2000 + p*16 + 3)};
    end
    src1[12] = {8'hFF, 64'hC0};
    for (int i = 1; i < 5; i++) src1[12+i] = {8'h00, 64'(32'hC0 + i)};
    src1[17] = {8'h01, 64'hC5};
    src0[12] = {8'hFF, 64'hF0};
    for (int i = 1; i < 5; i++) src0[12+i] = {8'h00, 64'(32'hF0 + i)};
    src0[17] = {8'h01, 64'hF5};
    src1[18] = {8'hFF, 64'h70};
    for (int i = 1; i < 7; i++) src1[18+i] = {8'h00, 64'(32'h70 + i)};
    src1[25] = {8'h01, 64'h77};
    src0[20] = {8'hFF, 64'h81};
    src0[21] = {8'hFE, 64'h82};
    src0[22] = {8'h00, 64'h83};
    src0[23] = {8'h00, 64'h84};
    src0[24] = {8'h80, 64'h85};
    src1[26] = {8'hFF, 64'h91};
    src1[27] = {8'h00, 64'h92};
    src1[28] = {8'h01, 64'h93};

    wr_port(0, 1'b0, '0);
    wr_port(1, 1'b0, '0);
    bus.out_rdy = 1'b1;

    // Reset state
    reset = 1'b0;
    tick();
    chk("rst_out_wr", 72'(bus.out_wr), 72'(0));
    chk("rst_in0_rdy", 72'(bus.in0_rdy), 72'(1));
    chk("rst_in1_rdy", 72'(bus.in1_rdy), 72'(1));
    tick();
    reset = 1'b1;
    tick();

    // Single port-0 packet, 2-cycle latency
    cap.delete();
    k = cyc;
    wr_port(0, 1'b1, {8'hFF, 64'd1}); tick();
    wr_port(0, 1'b1, {8'h00, 64'd2}); tick();
    wr_port(0, 1'b1, {8'h00, 64'd3}); tick();
    wr_port(0, 1'b1, {8'h01, 64'd4}); tick();
    wr_port(0, 1'b0, '0);
    repeat (6) tick();
    chk("t1_count", 72'(cap.size()), 72'(4));
    chk_word("t1_w0", 0, {8'hFF, 64'd1}, k + 2);
    chk_word("t1_w1", 1, {8'h00, 64'd2}, k + 3);
    chk_word("t1_w2", 2, {8'h00, 64'd3}, k + 4);
    chk_word("t1_w3", 3, {8'h01, 64'd4}, k + 5);
    chk("t1_in1_rdy", 72'(bus.in1_rdy), 72'(1));

    // Round robin with both ports pre-loaded
    reset = 1'b0; tick(); tick(); reset = 1'b1;
    cap.delete();
    bus.out_rdy = 1'b0;
    b = 0;
    fork
      feed(0, 0, 12);
      feed(1, 0, 12);
      begin
        repeat (5) tick();
        chk("t2_preload_in0_rdy", 72'(bus.in0_rdy), 72'(0));
        chk("t2_preload_in1_rdy", 72'(bus.in1_rdy), 72'(0));
        b = cyc;
        bus.out_rdy = 1'b1;
        repeat (40) tick();
      end
    join
    chk("t2_count", 72'(cap.size()), 72'(24));
    for (int j = 0; j < 24; j++) begin
      chk_word($sformatf("t2_w%0d", j), j,
               ((j % 8) < 4) ? src0[(j/8)*4 + j%4] : src1[(j/8)*4 + j%8 - 4],
               b + j + j/4);
    end

    // Output stall during port-1 BODY
    cap.delete();
    bus.out_rdy = 1'b0;
    fork
      feed(1, 12, 6);
      begin
        t = 0;
        while (bus.in1_rdy !== 1'b0 && t < 50) begin tick(); t++; end
        chk("t3_preload_full", 72'(bus.in1_rdy), 72'(0));
        bus.out_rdy = 1'b1; #1;
        chk("t3_a_wr", 72'(bus.out_wr), 72'(1));
        chk("t3_a_data", {bus.out_ctrl, bus.out_data}, src1[12]);
        tick();
        bus.out_rdy = 1'b1; #1;
        chk("t3_b_data", {bus.out_ctrl, bus.out_data}, src1[13]);
        tick();
        bus.out_rdy = 1'b1; #1;
        chk("t3_c_data", {bus.out_ctrl, bus.out_data}, src1[14]);
        tick();
        bus.out_rdy = 1'b0; #1;
        chk("t3_d_wr", 72'(bus.out_wr), 72'(0));
        chk("t3_d_data", {bus.out_ctrl, bus.out_data}, src1[15]);
        tick();
        bus.out_rdy = 1'b0; #1;
        chk("t3_e_wr", 72'(bus.out_wr), 72'(0));
        chk("t3_e_data", {bus.out_ctrl, bus.out_data}, src1[15]);
        tick();
        bus.out_rdy = 1'b1; #1;
        chk("t3_f_wr", 72'(bus.out_wr), 72'(1));
        chk("t3_f_data", {bus.out_ctrl, bus.out_data}, src1[15]);
        tick();
        repeat (8) tick();
      end
    join
    chk("t3_count", 72'(cap.size()), 72'(6));
    for (int j = 0; j < 6; j++) begin
      if (j < cap.size()) chk($sformatf("t3_seq%0d", j), {cap[j].c, cap[j].d}, src1[12+j]);
    end

    // Port-1 back-pressure while port 0 owns the output
    cap.delete();
    fed[0] = 0;
    fed[1] = 0;
    bus.out_rdy = 1'b1;
    k = cyc;
    fork
      feed(0, 12, 6);
      feed(1, 18, 8);
      begin
        repeat (5) tick();
        chk("t4_in1_rdy_low", 72'(bus.in1_rdy), 72'(0));
        chk("t4_in1_accepted", 72'(fed[1]), 72'(3));
        repeat (25) tick();
      end
    join
    chk("t4_count", 72'(cap.size()), 72'(14));
    for (int j = 0; j < 14; j++) begin
      chk_word($sformatf("t4_w%0d", j), j,
               (j < 6) ? src0[12+j] : src1[18+j-6],
               (j < 6) ? k + 2 + j : k + 3 + j);
    end

    // Reset in the middle of a port-0 packet while port 1 holds a packet
    cap.delete();
    wr_port(0, 1'b1, {8'hFF, 64'h50}); wr_port(1, 1'b1, {8'hFF, 64'h60}); tick();
    wr_port(0, 1'b1, {8'h00, 64'h51}); wr_port(1, 1'b1, {8'h00, 64'h61}); tick();
    wr_port(0, 1'b1, {8'h00, 64'h52}); wr_port(1, 1'b1, {8'h01, 64'h62}); tick();
    wr_port(0, 1'b1, {8'h00, 64'h53}); wr_port(1, 1'b0, '0); tick();
    wr_port(0, 1'b1, {8'h00, 64'h54}); tick();
    wr_port(0, 1'b0, '0);
    reset = 1'b0; #1;
    chk("t5_pre_wr", 72'(bus.out_wr), 72'(1));
    chk("t5_pre_data", {bus.out_ctrl, bus.out_data}, {8'h00, 64'h53});
    chk("t5_pre_in1_rdy", 72'(bus.in1_rdy), 72'(0));
    tick();
    chk("t5_post_wr", 72'(bus.out_wr), 72'(0));
    chk("t5_post_in0_rdy", 72'(bus.in0_rdy), 72'(1));
    chk("t5_post_in1_rdy", 72'(bus.in1_rdy), 72'(1));
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t5_flushed%0d", i), 72'(bus.out_wr), 72'(0));
    end
    cap.delete();
    k = cyc;
    wr_port(1, 1'b1, {8'hFF, 64'hD1}); tick();
    wr_port(1, 1'b1, {8'h00, 64'hD2}); tick();
    wr_port(1, 1'b1, {8'h01, 64'hD3}); tick();
    wr_port(1, 1'b0, '0);
    repeat (6) tick();
    chk("t5_fresh_count", 72'(cap.size()), 72'(3));
    chk_word("t5_fresh0", 0, {8'hFF, 64'hD1}, k + 2);
    chk_word("t5_fresh1", 1, {8'h00, 64'hD2}, k + 3);
    chk_word("t5_fresh2", 2, {8'h01, 64'hD3}, k + 4);

    // Multiple module headers; EOP only after a data word
    cap.delete();
    k = cyc;
    for (int i = 0; i < 5; i++) begin
      wr_port(0, 1'b1, src0[20+i]);
      if (i < 3) wr_port(1, 1'b1, src1[26+i]);
      else       wr_port(1, 1'b0, '0);
      tick();
    end
    wr_port(0, 1'b0, '0);
    wr_port(1, 1'b0, '0);
    repeat (10) tick();
    chk("t6_count", 72'(cap.size()), 72'(8));
    for (int j = 0; j < 8; j++) begin
      chk_word($sformatf("t6_w%0d", j), j,
               (j < 5) ? src0[20+j] : src1[26+j-5],
               (j < 5) ? k + 2 + j : k + 3 + j);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
